// File: rtl/uart_tx.sv
// FIFO-buffered UART transmitter: 8N1-style framing (WORD data bits, LSB first,
// one start and one stop bit), CLKS_PER_BIT clocks per bit, all outputs registered.
module uart_tx #(
  parameter int CLKS_PER_BIT = 0,
  parameter int WORD         = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            i_Clock,
  input  logic            i_Rst_L,
  input  logic            i_Tx_DV,
  input  logic [WORD-1:0] i_Tx_Byte,
  output logic            o_Tx_Ready,
  output logic            o_Tx_Serial,
  output logic            o_Tx_Active,
  output logic            o_Tx_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int SW = $clog2(WORD);
  localparam int IW = SW + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(WORD - 1);
  localparam logic [NW-1:0] COUNT_FULL = NW'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be at least 1");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [WORD-1:0] fifo_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [NW-1:0]   count_r, count_s;
  logic            ready_r;
  logic            full_s, empty_s, push_s, pop_s;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [IW-1:0]   idx_r, idx_s;
  logic [WORD-1:0] shift_r;
  logic            line_s, active_s, done_s;
  logic            serial_r, active_r, done_r;

  assign full_s  = (count_r == COUNT_FULL);
  assign empty_s = (count_r == NW'(0));
  assign push_s  = i_Tx_DV & ~full_s;

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_s = count_r;
    if (push_s && !pop_s) begin
      count_s = count_r + NW'(1);
    end else if (pop_s && !push_s) begin
      count_s = count_r - NW'(1);
    end else begin
      count_s = count_r;
    end
  end

  // FIFO storage; contents are only meaningful where count covers them, so no reset.
  always_ff @(posedge i_Clock) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= i_Tx_Byte;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= NW'(0);
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_s;
      ready_r <= (count_s != COUNT_FULL);
    end
  end

  // Frame sequencer: next state, counters and the unregistered line value.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    pop_s    = 1'b0;
    line_s   = 1'b1;
    active_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          cnt_s   = CW'(0);
          idx_s   = IW'(0);
          state_s = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        line_s   = 1'b0;
        active_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          cnt_s   = CW'(0);
          idx_s   = IW'(0);
          state_s = S_DATA;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_DATA: begin
        line_s   = shift_r[idx_r[SW-1:0]];
        active_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          cnt_s = CW'(0);
          if (idx_r == IDX_LAST) begin
            state_s = S_STOP;
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_STOP: begin
        line_s   = 1'b1;
        active_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          done_s  = 1'b1;
          cnt_s   = CW'(0);
          state_s = S_IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        cnt_s   = CW'(0);
        idx_s   = IW'(0);
        state_s = S_IDLE;
      end
    endcase
  end

  // Sequencer state, shift register and the registered line outputs (one cycle behind state).
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r  <= S_IDLE;
      cnt_r    <= CW'(0);
      idx_r    <= IW'(0);
      shift_r  <= WORD'(0);
      serial_r <= 1'b1;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      if (pop_s) begin
        shift_r <= fifo_r[rd_ptr_r];
      end
      serial_r <= line_s;
      active_r <= active_s;
      done_r   <= done_s;
    end
  end

  assign o_Tx_Ready  = ready_r;
  assign o_Tx_Serial = serial_r;
  assign o_Tx_Active = active_r;
  assign o_Tx_Done   = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: written words are queued and a line monitor
// decodes each frame cycle by cycle and compares it with the queue head.
module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int WORD  = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = CPB * (WORD + 2);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       ready, serial, active, done;

  uart_tx #(.CLKS_PER_BIT(CPB), .WORD(WORD), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(ready), .o_Tx_Serial(serial), .o_Tx_Active(active), .o_Tx_Done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int frames_seen = 0;
  logic [7:0] sb[$];
  int start_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Line monitor: captures a whole frame from its first low cycle, then checks the idle gap.
  initial begin : monitor
    logic [FRAME-1:0] line_v, act_v, done_v, exp_line, exp_done;
    logic [7:0] exp_b;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && serial === 1'b0) begin
        start_q.push_back(cyc);
        line_v = '0; act_v = '0; done_v = '0; aborted = 1'b0;
        line_v[0] = serial; act_v[0] = active; done_v[0] = done;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          line_v[i] = serial; act_v[i] = active; done_v[i] = done;
        end
        if (!aborted) begin
          frames_seen++;
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame: got line %h, no word was queued", line_v);
          end else begin
            exp_b = sb.pop_front();
            for (int i = 0; i < FRAME; i++) begin
              if (i < CPB) exp_line[i] = 1'b0;
              else if (i < CPB * (WORD + 1)) exp_line[i] = exp_b[(i - CPB) / CPB];
              else exp_line[i] = 1'b1;
            end
            exp_done = '0;
            exp_done[FRAME-1] = 1'b1;
            if (line_v !== exp_line) begin
              n_fail++;
              $display("FAIL frame_bits: got %h, expected %h (byte %h)", line_v, exp_line, exp_b);
            end
            n_cmp++;
            if (act_v !== {FRAME{1'b1}}) begin
              n_fail++;
              $display("FAIL frame_active: got %h, expected all ones", act_v);
            end
            n_cmp++;
            if (done_v !== exp_done) begin
              n_fail++;
              $display("FAIL frame_done: got %h, expected %h", done_v, exp_done);
            end
          end
          @(negedge clk);
          if (rst_n === 1'b1) begin
            n_cmp++;
            if (serial !== 1'b1 || active !== 1'b0 || done !== 1'b0) begin
              n_fail++;
              $display("FAIL idle_gap: got serial=%b active=%b done=%b, expected 1 0 0",
                       serial, active, done);
            end
          end
        end
      end
    end
  end

  task automatic drain(input int budget, output bit timed_out);
    int k = 0;
    while ((sb.size() != 0 || active !== 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    timed_out = (k >= budget);
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (serial !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b, expected 1", serial); end
    n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b, expected 0", active); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", ready); end
    dv = 1'b1; tx_byte = 8'hE7;
    repeat (2) @(negedge clk);
    dv = 1'b0;
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (serial !== 1'b1 || active !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL write_in_reset: got line activity, expected idle line"); end
  endtask

  task automatic test_single();
    int s0 = start_q.size();
    int d0 = done_cnt;
    int wr_cyc;
    bit to;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b, expected 1", ready); end
    dv = 1'b1; tx_byte = 8'hA5; sb.push_back(8'hA5);
    @(posedge clk);
    #1 wr_cyc = cyc; dv = 1'b0;
    drain(200, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL single_timeout: got %0d words pending, expected 0", sb.size()); end
    n_cmp++;
    if (start_q.size() != s0 + 1) begin
      n_fail++; $display("FAIL single_frames: got %0d, expected 1", start_q.size() - s0);
    end
    if (start_q.size() > s0) begin
      n_cmp++;
      if (start_q[s0] != wr_cyc + 2) begin
        n_fail++; $display("FAIL single_latency: got start %0d, expected %0d", start_q[s0], wr_cyc + 2);
      end
    end
    n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL single_done: got %0d, expected 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3] = '{8'h00, 8'hFF, 8'h3C};
    int s0 = start_q.size();
    int d0 = done_cnt;
    bit to;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b, expected 1", i, ready); end
      dv = 1'b1; tx_byte = words[i]; sb.push_back(words[i]);
    end
    @(negedge clk); dv = 1'b0;
    drain(400, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL b2b_timeout: got %0d words pending, expected 0", sb.size()); end
    n_cmp++;
    if (start_q.size() != s0 + 3) begin
      n_fail++; $display("FAIL b2b_frames: got %0d, expected 3", start_q.size() - s0);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (start_q[s0+i] - start_q[s0+i-1] != FRAME + 1) begin
          n_fail++; $display("FAIL b2b_gap%0d: got %0d cycles, expected %0d",
                             i, start_q[s0+i] - start_q[s0+i-1], FRAME + 1);
        end
      end
    end
    n_cmp++; if (done_cnt - d0 != 3) begin n_fail++; $display("FAIL b2b_done: got %0d, expected 3", done_cnt - d0); end
  endtask

  task automatic test_full();
    logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ready !== (i < 5)) begin
        n_fail++; $display("FAIL full_ready%0d: got %b, expected %b", i, ready, (i < 5));
      end
      dv = 1'b1; tx_byte = words[i];
      if (i < 5) sb.push_back(words[i]);
    end
    @(negedge clk); dv = 1'b0;
  endtask

  task automatic test_push_pop_full();
    bit after_done = 1'b0;
    bit accepted = 1'b0;
    dv = 1'b1; tx_byte = 8'h77;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ready !== after_done) begin
        n_fail++; $display("FAIL pushpop_ready: got %b, expected %b at cycle %0d", ready, after_done, cyc);
      end
      if (ready === 1'b1) begin
        sb.push_back(8'h77);
        @(posedge clk);
        #1 dv = 1'b0;
        accepted = 1'b1;
      end
      if (done === 1'b1) after_done = 1'b1;
    end
    dv = 1'b0;
    n_cmp++; if (!accepted) begin n_fail++; $display("FAIL pushpop_timeout: got no acceptance, expected one"); end
    @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL pushpop_refull: got ready %b, expected 0", ready); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] words [3] = '{8'h35, 8'h36, 8'h37};
    int d0;
    bit bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dv = 1'b1; tx_byte = words[i];
    end
    @(negedge clk); dv = 1'b0;
    repeat (17) @(negedge clk);
    n_cmp++;
    if (serial !== 1'b0 || active !== 1'b1) begin
      n_fail++; $display("FAIL mid_bit3: got serial=%b active=%b, expected 0 1", serial, active);
    end
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (serial !== 1'b1) begin n_fail++; $display("FAIL mid_serial: got %b, expected 1", serial); end
    n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL mid_active: got %b, expected 0", active); end
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b, expected 1", ready); end
    dv = 1'b1; tx_byte = 8'h99;
    repeat (3) @(negedge clk);
    dv = 1'b0;
    rst_n = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (serial !== 1'b1 || active !== 1'b0 || done !== 1'b0 || ready !== 1'b1) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL mid_after: got activity after reset, expected idle"); end
    n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL mid_done: got %0d pulses, expected 0", done_cnt - d0); end
  endtask

  task automatic test_loopback();
    int sent = 0;
    int k = 0;
    int f0 = frames_seen;
    logic [7:0] b;
    bit to;
    while (sent < 256 && k < 30000) begin
      @(negedge clk);
      k++;
      if (ready === 1'b1) begin
        b = 8'($urandom_range(0, 255));
        dv = 1'b1; tx_byte = b; sb.push_back(b); sent++;
      end else begin
        dv = 1'b0;
      end
    end
    @(negedge clk); dv = 1'b0;
    n_cmp++; if (sent != 256) begin n_fail++; $display("FAIL loop_sent: got %0d, expected 256", sent); end
    drain(400, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL loop_timeout: got %0d words pending, expected 0", sb.size()); end
    n_cmp++;
    if (frames_seen - f0 != 256) begin
      n_fail++; $display("FAIL loop_frames: got %0d, expected 256", frames_seen - f0);
    end
  endtask

  initial begin
    bit to;
    int d0;
    test_reset();
    test_single();
    test_back_to_back();
    d0 = done_cnt;
    test_full();
    test_push_pop_full();
    drain(600, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL full_timeout: got %0d words pending, expected 0", sb.size()); end
    n_cmp++; if (done_cnt - d0 != 6) begin n_fail++; $display("FAIL full_done: got %0d, expected 6", done_cnt - d0); end
    test_reset_mid();
    test_loopback();
    n_cmp++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d left, expected 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
